// File: rtl/functs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : functs (package)
// Description : Shared Q10 fixed-point types, widths and the truncating
//               divide-by-1024 helper for the shared multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package functs;

    localparam int Q10_FRAC = 10;
    localparam int Q10_W    = 32;
    localparam int PROD_W   = 2 * Q10_W;
    localparam int ID_W     = 3;   // covers up to 8 requesters

    typedef logic signed [Q10_W-1:0] q10_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } mul_tag_t;

    // Divide by 2^Q10_FRAC rounding toward zero rather than toward -inf.
    function automatic logic signed [PROD_W-1:0] q10_div(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W-1:0] q;
        q = p >>> Q10_FRAC;
        if (p[PROD_W-1] && (p[Q10_FRAC-1:0] != '0))
            q = q + 64'sd1;
        return q;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_q10_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mul_q10_pipe
// Description : LAT-cycle signed Q10 multiplier with requester-ID tag pipe.
//               Define MUL_Q10_SAT_EN to clamp results instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_q10_pipe
    import functs::*;
#(
    parameter int LAT = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    input  q10_t            in_a,
    input  q10_t            in_b,
    output mul_tag_t        out_tag,
    output q10_t            out_q
);

    mul_tag_t                 r_tag [LAT];
    q10_t                     r_a;
    q10_t                     r_b;
    logic signed [PROD_W-1:0] w_p;
    logic signed [PROD_W-1:0] w_q64;
    q10_t                     w_q;
    q10_t                     w_qfin;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int j = 0; j < LAT; j++)
                r_tag[j] <= '0;
        end else begin
            r_tag[0] <= '{valid: in_valid, id: in_id};
            for (int j = 1; j < LAT; j++)
                r_tag[j] <= r_tag[j-1];
        end
    end

    always_ff @(posedge clock) begin
        if (in_valid) begin
            r_a <= in_a;
            r_b <= in_b;
        end
    end

    assign w_p   = {{Q10_W{r_a[Q10_W-1]}}, r_a} * {{Q10_W{r_b[Q10_W-1]}}, r_b};
    assign w_q64 = q10_div(w_p);

`ifdef MUL_Q10_SAT_EN
    localparam logic signed [PROD_W-1:0] c_q_max = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [PROD_W-1:0] c_q_min = -64'sh0000_0000_8000_0000;

    always_comb begin
        w_q = w_q64[Q10_W-1:0];
        if (w_q64 > c_q_max)
            w_q = 32'h7FFF_FFFF;
        else if (w_q64 < c_q_min)
            w_q = 32'h8000_0000;
    end
`else
    logic w_unused_hi;
    assign w_q         = w_q64[Q10_W-1:0];
    assign w_unused_hi = ^w_q64[PROD_W-1:Q10_W];
`endif

    // Result pipeline runs one stage behind the tag, which also holds stage 0.
    generate
        if (LAT == 1) begin : g_lat1
            assign w_qfin = w_q;
        end else begin : g_latn
            q10_t r_qp [1:LAT-1];
            always_ff @(posedge clock) begin
                r_qp[1] <= w_q;
                for (int j = 2; j < LAT; j++)
                    r_qp[j] <= r_qp[j-1];
            end
            assign w_qfin = r_qp[LAT-1];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            out_tag <= '0;
            out_q   <= '0;
        end else begin
            out_tag <= r_tag[LAT-1];
            if (r_tag[LAT-1].valid)
                out_q <= w_qfin;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_q10_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mul_q10_arbiter
// Description : Round-robin sharing of one pipelined Q10 multiplier among
//               N_REQ requesters; results return to the issuing requester.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_q10_arbiter
    import functs::*;
#(
    parameter int N_REQ = 4,
    parameter int LAT   = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ-1:0][31:0] req_a,
    input  logic [N_REQ-1:0][31:0] req_b,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [31:0]            rsp_data
);

    logic [ID_W-1:0] r_ptr;
    logic            w_found;
    logic            w_grant;
    logic [ID_W-1:0] w_gid;
    int              w_idx;
    q10_t            w_a;
    q10_t            w_b;
    mul_tag_t        w_tag;
    q10_t            w_q;

    // First valid requester at or after ptr, wrapping at N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        w_idx   = 0;
        w_a     = '0;
        w_b     = '0;
        for (int off = 0; off < N_REQ; off++) begin
            w_idx = (int'(r_ptr) + off) % N_REQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gid   = ID_W'(w_idx);
                w_a     = req_a[w_idx];
                w_b     = req_b[w_idx];
            end
        end
    end

    assign w_grant = w_found && !reset;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++)
            req_ready[i] = w_grant && (w_gid == ID_W'(i));
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_ptr <= '0;
        else if (w_found)
            r_ptr <= (w_gid == ID_W'(N_REQ - 1)) ? '0 : w_gid + 1'b1;
    end

    mul_q10_pipe #(
        .LAT (LAT)
    ) u_pipe (
        .clock    (clock),
        .reset    (reset),
        .in_valid (w_grant),
        .in_id    (w_gid),
        .in_a     (w_a),
        .in_b     (w_b),
        .out_tag  (w_tag),
        .out_q    (w_q)
    );

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++)
            rsp_valid[i] = w_tag.valid && (w_tag.id == ID_W'(i));
    end

    assign rsp_data = w_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_q10_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_q10_arbiter
// Description : Directed self-checking bench for mul_q10_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_q10_arbiter;

    localparam int N_REQ = 4;
    localparam int LAT   = 3;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0][31:0] req_a = '0;
    logic [N_REQ-1:0][31:0] req_b = '0;
    logic [N_REQ-1:0]       rsp_valid;
    logic [31:0]            rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    mul_q10_arbiter #(
        .N_REQ (N_REQ),
        .LAT   (LAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Single transfer from one requester, then wait (bounded) for its response.
    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                         output logic [3:0] rv, output logic [31:0] rd, output int lat);
        req_a[id] = a;
        req_b[id] = b;
        req_valid = '0;
        req_valid[id] = 1'b1;
        step();
        req_valid = '0;
        rv  = '0;
        rd  = '0;
        lat = 0;
        for (int c = 1; c <= LAT + 4; c++) begin
            step();
            if (rsp_valid != '0) begin
                rv  = rsp_valid;
                rd  = rsp_data;
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'b1111;
        step();
        step();
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        n_checks++;
        if (rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid);
        end
        n_checks++;
        if (rsp_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data);
        end
        n_checks++;
        if (dut.r_ptr !== 3'd0) begin
            n_fail++; $display("FAIL reset_ptr: got %0d want 0", dut.r_ptr);
        end
        req_valid = '0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [3:0]  rv;
        logic [31:0] rd;
        int          lat;
        req_a[2] = 32'd1536;
        req_b[2] = 32'd2048;
        req_valid = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        issue(2, 32'd1536, 32'd2048, rv, rd, lat);
        n_checks++;
        if (lat !== LAT) begin
            n_fail++; $display("FAIL single_latency: got %0d want %0d", lat, LAT);
        end
        n_checks++;
        if (rv !== 4'b0100) begin
            n_fail++; $display("FAIL single_rsp_valid: got %b want 0100", rv);
        end
        n_checks++;
        if (rd !== 32'd3072) begin
            n_fail++; $display("FAIL single_rsp_data: got %h want %h", rd, 32'd3072);
        end
        step();
        n_checks++;
        if (rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL single_strobe_width: got %b want 0000", rsp_valid);
        end
        n_checks++;
        if (rsp_data !== 32'd3072) begin
            n_fail++; $display("FAIL single_data_hold: got %h want %h", rsp_data, 32'd3072);
        end
    endtask

    task automatic test_truncation();
        logic [31:0] va [5] = '{32'hFFFF_FA00, 32'hFFFF_F800, 32'hFFFF_FFFF, 32'd1537, 32'hFFFF_F400};
        logic [31:0] vb [5] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'hFFFF_FE00};
        logic [31:0] vq [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 32'd1, 32'd1536};
        logic [3:0]  rv;
        logic [31:0] rd;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            issue(i % N_REQ, va[i], vb[i], rv, rd, lat);
            n_checks++;
            if (rv !== 4'(1 << (i % N_REQ)) || lat !== LAT) begin
                n_fail++; $display("FAIL trunc_strobe[%0d]: got %b lat %0d want %b lat %0d",
                                   i, rv, lat, 4'(1 << (i % N_REQ)), LAT);
            end
            n_checks++;
            if (rd !== vq[i]) begin
                n_fail++; $display("FAIL trunc_data[%0d]: got %h want %h", i, rd, vq[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] va [2] = '{32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] vb [2] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
`ifdef MUL_Q10_SAT_EN
        logic [31:0] vq [2] = '{32'h7FFF_FFFF, 32'h8000_0000};
`else
        logic [31:0] vq [2] = '{32'hFFC0_0000, 32'h0020_0000};
`endif
        logic [3:0]  rv;
        logic [31:0] rd;
        int          lat;
        for (int i = 0; i < 2; i++) begin
            issue(i + 1, va[i], vb[i], rv, rd, lat);
            n_checks++;
            if (rd !== vq[i] || lat !== LAT) begin
                n_fail++; $display("FAIL overflow_data[%0d]: got %h lat %0d want %h lat %0d",
                                   i, rd, lat, vq[i], LAT);
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0]  rec_v [8+LAT];
        logic [31:0] rec_d [8+LAT];
        logic [3:0]  exp_v;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i] = 32'((i + 1) * 1024);
            req_b[i] = 32'((i + 1) * 512);
        end
        for (int s = 0; s < 8 + LAT; s++) begin
            req_valid = (s < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (s < 8) begin
                exp_v = 4'b0001 << (s % 4);
                n_checks++;
                if (req_ready !== exp_v) begin
                    n_fail++; $display("FAIL fair_grant[%0d]: got %b want %b", s, req_ready, exp_v);
                end
            end
            @(posedge clock);
            #1;
            rec_v[s] = rsp_valid;
            rec_d[s] = rsp_data;
        end
        for (int c = 0; c < 8; c++) begin
            exp_v = 4'b0001 << (c % 4);
            n_checks++;
            if (rec_v[c+LAT] !== exp_v || rec_d[c+LAT] !== 32'(512 * (c % 4 + 1) * (c % 4 + 1))) begin
                n_fail++; $display("FAIL fair_rsp[%0d]: got %b/%h want %b/%h", c, rec_v[c+LAT],
                                   rec_d[c+LAT], exp_v, 32'(512 * (c % 4 + 1) * (c % 4 + 1)));
            end
        end
    endtask

    task automatic test_sparse_wrap();
        logic [3:0]  grants [3] = '{4'b1000, 4'b0010, 4'b1000};
        logic [2:0]  ptrs   [3] = '{3'd0, 3'd2, 3'd0};
        logic [31:0] datas  [3] = '{32'd4096, 32'hFFFF_EC00, 32'd4096};
        logic [3:0]  rec_v [3+LAT];
        logic [31:0] rec_d [3+LAT];
        logic [3:0]  rv;
        logic [31:0] rd;
        int          lat;
        issue(1, 32'hFFFF_FC00, 32'd5120, rv, rd, lat);
        n_checks++;
        if (dut.r_ptr !== 3'd2) begin
            n_fail++; $display("FAIL sparse_ptr_start: got %0d want 2", dut.r_ptr);
        end
        req_a[3] = 32'd2048;
        req_b[3] = 32'd2048;
        for (int s = 0; s < 3 + LAT; s++) begin
            req_valid = (s < 3) ? 4'b1010 : 4'b0000;
            #1;
            if (s < 3) begin
                n_checks++;
                if (req_ready !== grants[s]) begin
                    n_fail++; $display("FAIL sparse_grant[%0d]: got %b want %b", s, req_ready, grants[s]);
                end
            end
            @(posedge clock);
            #1;
            if (s < 3) begin
                n_checks++;
                if (dut.r_ptr !== ptrs[s]) begin
                    n_fail++; $display("FAIL sparse_ptr[%0d]: got %0d want %0d", s, dut.r_ptr, ptrs[s]);
                end
            end
            rec_v[s] = rsp_valid;
            rec_d[s] = rsp_data;
        end
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (rec_v[c+LAT] !== grants[c] || rec_d[c+LAT] !== datas[c]) begin
                n_fail++; $display("FAIL sparse_rsp[%0d]: got %b/%h want %b/%h", c,
                                   rec_v[c+LAT], rec_d[c+LAT], grants[c], datas[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  rec_v [3+LAT];
        logic [31:0] rec_d [3+LAT];
        for (int s = 0; s < 3 + LAT; s++) begin
            req_valid = (s < 3) ? 4'b0100 : 4'b0000;
            req_a[2]  = 32'((s + 1) * 1024);
            req_b[2]  = 32'd3072;
            #1;
            if (s < 3) begin
                n_checks++;
                if (req_ready !== 4'b0100) begin
                    n_fail++; $display("FAIL b2b_grant[%0d]: got %b want 0100", s, req_ready);
                end
            end
            @(posedge clock);
            #1;
            rec_v[s] = rsp_valid;
            rec_d[s] = rsp_data;
        end
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (rec_v[c+LAT] !== 4'b0100 || rec_d[c+LAT] !== 32'(3072 * (c + 1))) begin
                n_fail++; $display("FAIL b2b_rsp[%0d]: got %b/%h want 0100/%h", c,
                                   rec_v[c+LAT], rec_d[c+LAT], 32'(3072 * (c + 1)));
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) begin
            req_a[i] = 32'd1024;
            req_b[i] = 32'(1024 * (i + 1));
        end
        req_valid = 4'b0111;
        for (int s = 0; s < 3; s++)
            step();
        reset = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_ready: got %b want 0000", req_ready);
        end
        step();
        reset = 1'b0;
        req_valid = '0;
        n_checks++;
        if (dut.r_ptr !== 3'd0) begin
            n_fail++; $display("FAIL midrst_ptr: got %0d want 0", dut.r_ptr);
        end
        for (int s = 0; s < LAT + 2; s++) begin
            n_checks++;
            if (rsp_valid !== 4'b0000) begin
                n_fail++; $display("FAIL midrst_no_rsp[%0d]: got %b want 0000", s, rsp_valid);
            end
            step();
        end
        req_valid = 4'b0110;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL midrst_first_grant: got %b want 0010", req_ready);
        end
        step();
        req_valid = '0;
        for (int s = 0; s < LAT + 1; s++)
            step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_truncation();
        test_overflow();
        test_fairness();
        test_sparse_wrap();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
